// File: rtl/acc_pkg.sv
// Shared types and defaults for the accelerator offload tracker.
package acc_pkg;

   localparam int unsigned NumWb     = 2;
   localparam int unsigned AddrWidth = 16;
   localparam int unsigned Depth     = 4;
   localparam int unsigned RdWidth   = 5;
   localparam int unsigned NumRegs   = 32;

   // One in-flight offload slot.
   typedef struct packed {
      logic                            valid;
      logic                            done;
      logic                            error;
      logic [AddrWidth-1:0]            addr;
      logic [NumWb-1:0]                wb;
      logic [NumWb-1:0][RdWidth-1:0]   rd;
   } acc_trk_entry_t;

   // One-hot register mask; x0 never maps to a bit.
   function automatic logic [NumRegs-1:0] rd_mask(input logic [RdWidth-1:0] rd);
      logic [NumRegs-1:0] m;
      m = '0;
      if (rd != '0) m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/acc_rd_scoreboard.sv
// Pending-destination bitmap: set on issue, clear on retire, wiped on flush.
module acc_rd_scoreboard
   import acc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [NumRegs-1:0] set_mask,
   input  logic [NumRegs-1:0] clr_mask,
   output logic [NumRegs-1:0] busy
);

   // Set wins over clear; bit 0 is always forced low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         busy <= ((busy & ~clr_mask) | set_mask) & ~NumRegs'(1);
      end
   end

endmodule

// File: rtl/acc_offload_tracker.sv
// In-order retire tracker for offloaded instructions with out-of-order completion.
module acc_offload_tracker #(
   parameter  int unsigned Depth     = acc_pkg::Depth,
   parameter  int unsigned NumWb     = acc_pkg::NumWb,
   parameter  int unsigned AddrWidth = acc_pkg::AddrWidth,
   localparam int unsigned IdWidth   = $clog2(Depth)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      issue_valid_i,
   output logic                      issue_ready_o,
   input  logic [AddrWidth-1:0]      issue_addr_i,
   input  logic [NumWb-1:0]          issue_wb_i,
   input  logic [NumWb-1:0][4:0]     issue_rd_i,
   output logic [IdWidth-1:0]        issue_id_o,
   input  logic                      rsp_valid_i,
   input  logic [IdWidth-1:0]        rsp_id_i,
   input  logic                      rsp_error_i,
   output logic                      retire_valid_o,
   input  logic                      retire_ready_i,
   output logic [AddrWidth-1:0]      retire_addr_o,
   output logic [NumWb-1:0]          retire_wb_o,
   output logic [NumWb-1:0][4:0]     retire_rd_o,
   output logic                      retire_error_o,
   output logic [31:0]               busy_rd_o,
   output logic [IdWidth:0]          count_o,
   output logic                      spurious_o
);

   import acc_pkg::acc_trk_entry_t;
   import acc_pkg::rd_mask;

   localparam int unsigned CntWidth = IdWidth + 1;
   localparam int unsigned EntAddrW = acc_pkg::AddrWidth;
   localparam int unsigned EntNumWb = acc_pkg::NumWb;
   localparam int unsigned EntRdW   = acc_pkg::NumWb * acc_pkg::RdWidth;
   localparam int unsigned RdBits   = NumWb * acc_pkg::RdWidth;

   acc_trk_entry_t          entries [Depth];
   acc_trk_entry_t          head_ent;
   acc_trk_entry_t          new_ent;
   logic [IdWidth-1:0]      head;
   logic [IdWidth-1:0]      tail;
   logic [CntWidth-1:0]     count;
   logic                    spurious;
   logic [31:0]             busy;
   logic [31:0]             set_mask;
   logic [31:0]             clr_mask;
   logic [31:0]             sb_set;
   logic [31:0]             sb_clr;
   logic                    hazard;
   logic                    issue_fire;
   logic                    retire_fire;
   logic                    rsp_match;

   assign head_ent       = entries[head];
   assign issue_id_o     = tail;
   assign retire_valid_o = head_ent.valid & head_ent.done;
   assign retire_addr_o  = AddrWidth'(head_ent.addr);
   assign retire_wb_o    = NumWb'(head_ent.wb);
   assign retire_rd_o    = RdBits'(head_ent.rd);
   assign retire_error_o = head_ent.error;
   assign busy_rd_o      = busy;
   assign count_o        = count;
   assign spurious_o     = spurious;

   // Handshake qualification, WAW hazard detection and scoreboard masks.
   always_comb begin
      hazard   = 1'b0;
      set_mask = '0;
      clr_mask = '0;
      for (int k = 0; k < NumWb; k++) begin
         if (issue_wb_i[k] && (issue_rd_i[k] != '0) && busy[issue_rd_i[k]]) hazard = 1'b1;
         if (issue_wb_i[k]) set_mask = set_mask | rd_mask(issue_rd_i[k]);
      end
      for (int k = 0; k < EntNumWb; k++) begin
         if (head_ent.wb[k]) clr_mask = clr_mask | rd_mask(head_ent.rd[k]);
      end
      issue_ready_o = (count < CntWidth'(Depth)) && !flush_i && !hazard;
      issue_fire    = issue_valid_i & issue_ready_o;
      retire_fire   = retire_valid_o & retire_ready_i;
      rsp_match     = rsp_valid_i & entries[rsp_id_i].valid & ~entries[rsp_id_i].done;
      sb_set        = issue_fire  ? set_mask : '0;
      sb_clr        = retire_fire ? clr_mask : '0;
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.addr  = EntAddrW'(issue_addr_i);
      new_ent.wb    = EntNumWb'(issue_wb_i);
      new_ent.rd    = EntRdW'(issue_rd_i);
   end

   // Entry array, pointers, occupancy and spurious-response pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) entries[i] <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         spurious <= 1'b0;
      end else if (flush_i) begin
         for (int i = 0; i < Depth; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].done  <= 1'b0;
         end
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         spurious <= 1'b0;
      end else begin
         spurious <= rsp_valid_i & ~rsp_match;
         if (rsp_match) begin
            entries[rsp_id_i].done  <= 1'b1;
            entries[rsp_id_i].error <= rsp_error_i;
         end
         if (retire_fire) begin
            entries[head].valid <= 1'b0;
            entries[head].done  <= 1'b0;
            head                <= head + IdWidth'(1);
         end
         if (issue_fire) begin
            entries[tail] <= new_ent;
            tail          <= tail + IdWidth'(1);
         end
         unique case ({issue_fire, retire_fire})
            2'b10:   count <= count + CntWidth'(1);
            2'b01:   count <= count - CntWidth'(1);
            default: count <= count;
         endcase
      end
   end

   acc_rd_scoreboard u_scoreboard (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (flush_i),
      .set_mask (sb_set),
      .clr_mask (sb_clr),
      .busy     (busy)
   );

endmodule
